// File: rtl/rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame
// Purpose  : RGMII receive framer. Rebuilds bytes from the DDR nibble stream,
//            skips HDR_LEN header bytes, collects CTRL_LEN control bytes and
//            streams the payload with a byte index, then reports per-frame
//            status (length, error, runt, overflow) at frame end.
// Ports    : rxclk      - receive clock, both edges used
//            rst_n      - synchronous active-low reset (rising rxclk)
//            rxctl      - RGMII control (rise: dv, fall: dv ^ er)
//            rxd[3:0]   - RGMII DDR data nibble
//            dout/addr/dout_vld      - payload byte, its index, strobe
//            ctrl/ctrl_vld           - control word (first byte in MSBs), strobe
//            len/frame_err/runt/ovf  - status of last frame, updated with
//            frame_done                one-cycle frame end strobe
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame #(
  parameter int HDR_LEN  = 24,
  parameter int CTRL_LEN = 1,
  parameter int AW       = 14,
  parameter int NIB_SWAP = 0
) (
  input  logic                  rxclk,
  input  logic                  rst_n,
  input  logic                  rxctl,
  input  logic [3:0]            rxd,
  output logic [7:0]            dout,
  output logic                  dout_vld,
  output logic [AW-1:0]         addr,
  output logic [8*CTRL_LEN-1:0] ctrl,
  output logic                  ctrl_vld,
  output logic [AW-1:0]         len,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  runt,
  output logic                  ovf
);

  // Counter must reach both the header/control lengths and 2^AW (saturation).
  localparam int HW = $clog2(HDR_LEN + CTRL_LEN + 1);
  localparam int KW = (AW + 1 > HW) ? AW + 1 : HW;
  localparam logic [KW-1:0] PAY_MAX = KW'(1 << AW);
  localparam logic [KW-1:0] LEN_SAT = KW'((1 << AW) - 1);

  typedef enum logic [1:0] {IDLE, HDR, CTRL, DATA} state_t;

  // --------------------------------------------------------------------------
  // Capture pipeline. Deliberately free-running (no reset): after a reset the
  // FSM must observe the real line dv, not a reset-forced zero, before it is
  // allowed to start a new frame.
  // --------------------------------------------------------------------------
  logic [3:0] lo_q, hi_fall_q;
  logic       dv_q, ctl_fall_q;
  logic [7:0] byte_q, byte_d;
  logic       bvld_q, bvld_d;
  logic       ber_q, ber_d;

  always_ff @(negedge rxclk) begin
    hi_fall_q  <= rxd;
    ctl_fall_q <= rxctl;
  end

  always_comb begin
    bvld_d = dv_q;
    ber_d  = dv_q & (dv_q ^ ctl_fall_q);
    byte_d = (NIB_SWAP != 0) ? {lo_q, hi_fall_q} : {hi_fall_q, lo_q};
  end

  always_ff @(posedge rxclk) begin
    lo_q   <= rxd;
    dv_q   <= rxctl;
    byte_q <= byte_d;
    bvld_q <= bvld_d;
    ber_q  <= ber_d;
  end

  // --------------------------------------------------------------------------
  // Control word assembly: earlier control bytes sit in a shift register, the
  // current byte completes the word in its LSBs.
  // --------------------------------------------------------------------------
  logic [8*CTRL_LEN-1:0] ctrl_word;
  logic                  ctrl_byte;

  generate
    if (CTRL_LEN == 1) begin : g_ctrl_single
      logic ctrl_byte_unused;
      assign ctrl_byte_unused = ctrl_byte;
      assign ctrl_word        = byte_q;
    end else begin : g_ctrl_shift
      logic [8*(CTRL_LEN-1)-1:0] shift_q, shift_d;
      always_comb begin
        shift_d = shift_q;
        if (ctrl_byte) shift_d = ctrl_word[8*(CTRL_LEN-1)-1:0];
      end
      always_ff @(posedge rxclk) begin
        shift_q <= shift_d;
      end
      assign ctrl_word = {shift_q, byte_q};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t                state_q, state_d, cur_state;
  logic [KW-1:0]         k_q, k_d, cur_k;
  logic                  err_q, err_d, cur_err;
  logic                  ovfacc_q, ovfacc_d, cur_ovf;
  logic                  wait_low_q, wait_low_d;
  logic [7:0]            dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [8*CTRL_LEN-1:0] ctrl_q, ctrl_d;
  logic                  ctrl_vld_q, ctrl_vld_d;
  logic [AW-1:0]         len_q, len_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;
  logic                  runt_q, runt_d;
  logic                  ovf_q, ovf_d;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    err_d        = err_q;
    ovfacc_d     = ovfacc_q;
    wait_low_d   = wait_low_q;
    dout_d       = dout_q;
    dout_vld_d   = 1'b0;
    addr_d       = addr_q;
    ctrl_d       = ctrl_q;
    ctrl_vld_d   = 1'b0;
    len_d        = len_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    runt_d       = runt_q;
    ovf_d        = ovf_q;
    ctrl_byte    = 1'b0;

    // The first byte of a frame is handled as if already in HDR (or CTRL when
    // there is no header), with fresh counters and status.
    cur_state = state_q;
    cur_k     = k_q;
    cur_err   = err_q | ber_q;
    cur_ovf   = ovfacc_q;
    if (state_q == IDLE) begin
      cur_state = (HDR_LEN == 0) ? CTRL : HDR;
      cur_k     = '0;
      cur_err   = ber_q;
      cur_ovf   = 1'b0;
    end

    if (!bvld_q) begin
      wait_low_d = 1'b0;
      if (state_q != IDLE) begin
        frame_done_d = 1'b1;
        frame_err_d  = err_q;
        runt_d       = (state_q != DATA);
        ovf_d        = ovfacc_q;
        if (state_q != DATA)     len_d = '0;
        else if (k_q >= LEN_SAT) len_d = LEN_SAT[AW-1:0];
        else                     len_d = k_q[AW-1:0];
        state_d = IDLE;
        k_d     = '0;
      end
    end else if (!(state_q == IDLE && wait_low_q)) begin
      state_d  = cur_state;
      err_d    = cur_err;
      ovfacc_d = cur_ovf;
      k_d      = cur_k + KW'(1);
      case (cur_state)
        HDR: begin
          if (cur_k == KW'(HDR_LEN - 1)) begin
            state_d = CTRL;
            k_d     = '0;
          end
        end
        CTRL: begin
          ctrl_byte = 1'b1;
          if (cur_k == KW'(CTRL_LEN - 1)) begin
            ctrl_d     = ctrl_word;
            ctrl_vld_d = 1'b1;
            state_d    = DATA;
            k_d        = '0;
          end
        end
        DATA: begin
          if (cur_k < PAY_MAX) begin
            dout_d     = byte_q;
            addr_d     = cur_k[AW-1:0];
            dout_vld_d = 1'b1;
          end else begin
            // Beyond the address space: drop the byte, hold the count.
            ovfacc_d = 1'b1;
            k_d      = cur_k;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rxclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      err_q        <= 1'b0;
      ovfacc_q     <= 1'b0;
      wait_low_q   <= 1'b1;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      addr_q       <= '0;
      ctrl_q       <= '0;
      ctrl_vld_q   <= 1'b0;
      len_q        <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      runt_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      err_q        <= err_d;
      ovfacc_q     <= ovfacc_d;
      wait_low_q   <= wait_low_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      addr_q       <= addr_d;
      ctrl_q       <= ctrl_d;
      ctrl_vld_q   <= ctrl_vld_d;
      len_q        <= len_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      runt_q       <= runt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign addr       = addr_q;
  assign ctrl       = ctrl_q;
  assign ctrl_vld   = ctrl_vld_q;
  assign len        = len_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign runt       = runt_q;
  assign ovf        = ovf_q;

endmodule
`default_nettype wire
